// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and queues returned instructions in a 2-entry FIFO that
// feeds decode. Redirects from execute flush the queue and restart fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        Imem_req_o,
  output logic [31:0] Imem_addr_o,
  input  logic        Imem_gnt_i,
  input  logic        Imem_rvalid_i,
  input  logic [31:0] Imem_rdata_i,
  input  logic        Redirect_i,
  input  logic [31:0] Redirect_pc_i,
  input  logic        ID_Ready_i,
  output logic        ID_Valid_o,
  output logic [31:0] ID_Instruction_o,
  output logic [31:0] ID_PC_o
);

  typedef enum logic [1:0] {StReq, StWait, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];

  logic push, pop, wr_ptr;
  logic unused_redirect_lsb;

  // Target low bits are forced to zero, so they are intentionally dropped.
  assign unused_redirect_lsb = ^Redirect_pc_i[1:0];

  // FIFO bookkeeping: a redirect flushes the queue and suppresses push and pop.
  always_comb begin
    pop    = (count_q != 2'd0) && ID_Ready_i && !Redirect_i;
    push   = (state_q == StWait) && Imem_rvalid_i && !Redirect_i;
    wr_ptr = rd_ptr_q ^ (count_q == 2'd1);

    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    if (push) begin
      fifo_pc_d[wr_ptr]    = issued_pc_q;
      fifo_instr_d[wr_ptr] = Imem_rdata_i;
    end

    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    if (Redirect_i) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Fetch FSM and PC next-state; redirect overrides the PC in every state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;

    unique case (state_q)
      StReq: begin
        if (Imem_gnt_i) begin
          issued_pc_d = pc_q;
          pc_d        = pc_q + 32'd4;
          // A fetch granted alongside a redirect is stale and must be drained.
          state_d     = Redirect_i ? StDrain : StWait;
        end
      end
      StWait: begin
        if (Imem_rvalid_i) begin
          state_d = (count_d == 2'd2) ? StHold : StReq;
        end else if (Redirect_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (Imem_rvalid_i) state_d = StReq;
      end
      StHold: begin
        if (Redirect_i || (count_q < 2'd2)) state_d = StReq;
      end
      default: state_d = StReq;
    endcase

    if (Redirect_i) pc_d = {Redirect_pc_i[31:2], 2'b00};
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      issued_pc_q  <= RESET_PC;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      fifo_pc_q    <= '{default: 32'd0};
      fifo_instr_q <= '{default: 32'd0};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issued_pc_q  <= issued_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  // Outputs depend only on flops; no input reaches them combinationally.
  always_comb begin
    Imem_req_o       = (state_q == StReq);
    Imem_addr_o      = pc_q;
    ID_Valid_o       = (count_q != 2'd0);
    ID_Instruction_o = ID_Valid_o ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
    ID_PC_o          = ID_Valid_o ? fifo_pc_q[rd_ptr_q] : 32'd0;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready, id_valid;
  logic [31:0] id_instr, id_pc;

  logic        gnt_en;
  int          lat;
  logic        pend_q;
  int          cnt_q;
  logic [31:0] paddr_q;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .Imem_req_o      (imem_req),
    .Imem_addr_o     (imem_addr),
    .Imem_gnt_i      (imem_gnt),
    .Imem_rvalid_i   (imem_rvalid),
    .Imem_rdata_i    (imem_rdata),
    .Redirect_i      (redirect),
    .Redirect_pc_i   (redirect_pc),
    .ID_Ready_i      (id_ready),
    .ID_Valid_o      (id_valid),
    .ID_Instruction_o(id_instr),
    .ID_PC_o         (id_pc)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: grant while enabled, respond lat cycles after the grant cycle + 1.
  assign imem_gnt    = imem_req && gnt_en;
  assign imem_rvalid = pend_q && (cnt_q == 0);
  assign imem_rdata  = imem_rvalid ? data_of(paddr_q) : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      cnt_q   <= 0;
      paddr_q <= 32'h0;
    end else if (imem_req && imem_gnt) begin
      pend_q  <= 1'b1;
      cnt_q   <= lat;
      paddr_q <= imem_addr;
    end else if (imem_rvalid) begin
      pend_q <= 1'b0;
    end else if (pend_q && cnt_q != 0) begin
      cnt_q <= cnt_q - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50 && !imem_req; i++) step();
    check_eq({tag, " req"}, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !id_valid; i++) step();
    check_eq({tag, " valid"}, 32'(id_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; gnt_en = 1'b1; lat = 0; id_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) step();
    check_eq("rst req", 32'(imem_req), 32'd1);
    check_eq("rst addr", imem_addr, 32'h0);
    check_eq("rst valid", 32'(id_valid), 32'd0);
    check_eq("rst instr", id_instr, Nop);
    check_eq("rst pc", id_pc, 32'h0);

    // Zero-wait streaming: deliveries at cycles 2, 4, 6.
    rst_n = 1'b1;
    check_eq("c0 req", 32'(imem_req), 32'd1);
    check_eq("c0 addr", imem_addr, 32'h0);
    step();
    check_eq("c1 req", 32'(imem_req), 32'd0);
    step();
    check_eq("c2 valid", 32'(id_valid), 32'd1);
    check_eq("c2 pc", id_pc, 32'h0);
    check_eq("c2 instr", id_instr, data_of(32'h0));
    check_eq("c2 addr", imem_addr, 32'h4);
    step();
    check_eq("c3 valid", 32'(id_valid), 32'd0);
    step();
    check_eq("c4 pc", id_pc, 32'h4);
    repeat (2) step();
    check_eq("c6 pc", id_pc, 32'h8);
    check_eq("c6 instr", id_instr, data_of(32'h8));

    // Decode stall: queue fills, fetch holds, then drains in order.
    id_ready = 1'b0;
    repeat (10) step();
    check_eq("stall valid", 32'(id_valid), 32'd1);
    check_eq("stall pc", id_pc, 32'h8);
    check_eq("stall req", 32'(imem_req), 32'd0);
    id_ready = 1'b1;
    step();
    check_eq("drain pc", id_pc, 32'hC);
    check_eq("drain instr", id_instr, data_of(32'hC));
    step();
    wait_req("resume");
    check_eq("resume addr", imem_addr, 32'h10);
    wait_valid("resume");
    check_eq("resume pc", id_pc, 32'h10);

    // Redirect while waiting with one entry queued; late response dropped.
    step();
    id_ready = 1'b0;
    wait_valid("queued");
    lat = 3;
    wait_req("wait redir");
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check_eq("wredir flush", 32'(id_valid), 32'd0);
    check_eq("wredir drain", 32'(imem_req), 32'd0);
    id_ready = 1'b1; lat = 0;
    wait_req("wredir");
    check_eq("wredir addr", imem_addr, 32'h100);
    wait_valid("wredir");
    check_eq("wredir pc", id_pc, 32'h100);
    check_eq("wredir instr", id_instr, data_of(32'h100));

    // Redirect coinciding with rvalid.
    step();
    wait_req("rv redir");
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check_eq("rvredir valid", 32'(id_valid), 32'd0);
    check_eq("rvredir req", 32'(imem_req), 32'd1);
    check_eq("rvredir addr", imem_addr, 32'h200);
    wait_valid("rvredir");
    check_eq("rvredir pc", id_pc, 32'h200);
    check_eq("rvredir instr", id_instr, data_of(32'h200));

    // Redirect coinciding with grant.
    step();
    wait_req("gnt redir");
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    check_eq("gredir drain", 32'(imem_req), 32'd0);
    step();
    check_eq("gredir addr", imem_addr, 32'h300);
    wait_valid("gredir");
    check_eq("gredir pc", id_pc, 32'h300);

    // Back-to-back redirects while grant is withheld: last wins.
    step();
    gnt_en = 1'b0;
    wait_req("b2b");
    redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_pc = 32'h500;
    step();
    redirect = 1'b0;
    check_eq("b2b addr", imem_addr, 32'h500);
    gnt_en = 1'b1;
    wait_valid("b2b");
    check_eq("b2b pc", id_pc, 32'h500);

    // PC wrap from the top of the address space.
    step();
    wait_req("wrap");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    wait_valid("wrap hi");
    check_eq("wrap hi pc", id_pc, 32'hFFFF_FFFC);
    check_eq("wrap next addr", imem_addr, 32'h0);
    step();
    wait_valid("wrap lo");
    check_eq("wrap lo pc", id_pc, 32'h0);
    check_eq("wrap lo instr", id_instr, data_of(32'h0));

    // Asynchronous reset in the middle of an outstanding fetch.
    step();
    id_ready = 1'b0;
    wait_valid("pre rst");
    lat = 3;
    wait_req("pre rst");
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst valid", 32'(id_valid), 32'd0);
    check_eq("arst instr", id_instr, Nop);
    check_eq("arst req", 32'(imem_req), 32'd1);
    check_eq("arst addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1; id_ready = 1'b1; lat = 0;
    check_eq("post rst addr", imem_addr, 32'h0);
    wait_valid("post rst 0");
    check_eq("post rst pc0", id_pc, 32'h0);
    step();
    wait_valid("post rst 4");
    check_eq("post rst pc4", id_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
